game_timer: RTL and testbench

GAME_TIMER -- requirements
Module: game_timer

---
 rtl/wam_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 37 +++
 rtl/game_timer.sv | 131 +++++++++++++
 tb/tb_game_timer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/wam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wam_pkg
// Description : Shared FSM encoding and seconds-field constants for game_timer
// Revision    : 1.0 - initial release
// ============================================================================
package wam_pkg;

    localparam int MAX_SEC = 63;
    localparam int SEC_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Divide-by-CLK_HZ counter producing a one-cycle tick on wrap
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int CLK_HZ = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int                 c_cnt_w = $clog2(CLK_HZ);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLK_HZ - 1);

    logic [c_cnt_w-1:0] r_count;
    logic               w_wrap;

    assign w_wrap = (r_count == c_last);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_wrap ? '0 : r_count + 1'b1;
        end
    end

    // The wrap cycle itself is the tick; a clear in the same cycle cancels it.
    assign tick = enable && w_wrap && !clear;

endmodule
`default_nettype wire

// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
// Module      : game_timer
// Description : Round countdown timer with pause, bonus time and expiry pulse
// Revision    : 1.0 - initial release
// ============================================================================
module game_timer
    import wam_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int START_SEC = 60,
    parameter int BONUS_SEC = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             add_time,
    output logic [SEC_W-1:0] seconds,
    output logic             running,
    output logic             done,
    output logic             time_up
);

    localparam int                 c_sum_w = SEC_W + 1;
    localparam logic [SEC_W-1:0]   c_start = SEC_W'(START_SEC);
    localparam logic [c_sum_w-1:0] c_bonus = c_sum_w'(BONUS_SEC);
    localparam logic [c_sum_w-1:0] c_max   = c_sum_w'(MAX_SEC);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEC_W-1:0]   r_seconds;
    logic [SEC_W-1:0]   w_seconds_nxt;
    logic               r_time_up;
    logic               r_running;
    logic               r_done;
    logic               w_expire;
    logic               w_tick;
    logic               w_pre_en;
    logic               w_pre_clr;
    logic [c_sum_w-1:0] w_sum;
    logic [SEC_W-1:0]   w_sum_sat;

    tick_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (w_pre_en),
        .clear  (w_pre_clr),
        .tick   (w_tick)
    );

    // Bonus arithmetic is one bit wider so overflow past 63 can be saturated;
    // a coincident tick folds its decrement into the same sum.
    always_comb begin
        w_sum = {1'b0, r_seconds} + c_bonus;
        if (r_state == ST_RUN && w_tick) begin
            w_sum = w_sum - c_sum_w'(1);
        end
        w_sum_sat = (w_sum > c_max) ? c_max[SEC_W-1:0] : w_sum[SEC_W-1:0];
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_seconds_nxt = r_seconds;
        w_expire      = 1'b0;
        w_pre_en      = (r_state == ST_RUN);
        w_pre_clr     = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt   = ST_RUN;
                    w_seconds_nxt = c_start;
                    w_pre_clr     = 1'b1;
                end
            end
            ST_RUN: begin
                if (add_time) begin
                    w_seconds_nxt = w_sum_sat;
                end else if (w_tick) begin
                    if (r_seconds <= SEC_W'(1)) begin
                        w_seconds_nxt = '0;
                        w_state_nxt   = ST_DONE;
                        w_expire      = 1'b1;
                    end else begin
                        w_seconds_nxt = r_seconds - 1'b1;
                    end
                end
                if (pause && !w_expire) begin
                    w_state_nxt = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (add_time) begin
                    w_seconds_nxt = w_sum_sat;
                end
                if (!pause) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_seconds <= c_start;
            r_time_up <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_seconds <= w_seconds_nxt;
            r_time_up <= w_expire;
            r_running <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

    assign seconds = r_seconds;
    assign running = r_running;
    assign done    = r_done;
    assign time_up = r_time_up;

endmodule
`default_nettype wire

// File: tb/tb_game_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_timer
// Description : Scoreboard bench for game_timer (CLK_HZ=4, START=3, BONUS=5)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_timer;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       pause    = 1'b0;
    logic       add_time = 1'b0;
    logic [5:0] seconds;
    logic       running;
    logic       done;
    logic       time_up;

    typedef struct {
        int   vec;
        int   sec;
        logic run;
        logic dn;
        logic tu;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_id   = 0;

    game_timer #(
        .CLK_HZ    (4),
        .START_SEC (3),
        .BONUS_SEC (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pause    (pause),
        .add_time (add_time),
        .seconds  (seconds),
        .running  (running),
        .done     (done),
        .time_up  (time_up)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int vec, input logic [31:0] got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s vec=%0d: got %0d expected %0d", nm, vec, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic s, input logic p, input logic a,
                        input int es, input logic er, input logic ed, input logic etu);
        exp_t e;
        @(negedge clk);
        reset    = r;
        start    = s;
        pause    = p;
        add_time = a;
        vec_id++;
        e.vec = vec_id;
        e.sec = es;
        e.run = er;
        e.dn  = ed;
        e.tu  = etu;
        q.push_back(e);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("seconds", e.vec, {26'b0, seconds}, e.sec);
            chk("running", e.vec, {31'b0, running}, int'(e.run));
            chk("done",    e.vec, {31'b0, done},    int'(e.dn));
            chk("time_up", e.vec, {31'b0, time_up}, int'(e.tu));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tail[7] = '{62, 62, 61, 61, 61, 61, 60};

        // Reset state, then pause/add_time ignored in IDLE
        step(1, 0, 0, 0, 3, 0, 0, 0);
        step(1, 0, 0, 0, 3, 0, 0, 0);
        step(0, 0, 1, 1, 3, 0, 0, 0);

        // Full round; a start pulse mid-round must not reload
        step(0, 1, 0, 0, 3, 1, 0, 0);
        for (int i = 1; i <= 11; i++) step(0, (i == 6), 0, 0, 3 - i / 4, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 1, 0);

        // DONE ignores add_time, start restarts
        step(0, 0, 0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 3, 1, 0, 0);

        // Pause for 10 cycles with prescaler at 2; one cycle left after release
        step(0, 0, 0, 0, 3, 1, 0, 0);
        step(0, 0, 0, 0, 3, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 3, 0, 0, 0);
        step(0, 0, 0, 0, 3, 1, 0, 0);
        step(0, 0, 0, 0, 2, 1, 0, 0);

        // Build up to 62 with bonuses (first one in RUN, rest while PAUSED)
        for (int k = 0; k < 12; k++) step(0, 0, 1, 1, 7 + 5 * k, 0, 0, 0);
        step(0, 0, 0, 0, 62, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, tail[i], 1, 0, 0);
        // 60 + 5 saturates, then 63 + 5 saturates
        step(0, 0, 0, 1, 63, 1, 0, 0);
        step(0, 0, 0, 1, 63, 1, 0, 0);

        // seconds=1 with add_time on the tick -> 5, no expiry
        step(1, 0, 0, 0, 3, 0, 0, 0);
        step(0, 1, 0, 0, 3, 1, 0, 0);
        for (int i = 1; i <= 11; i++) step(0, 0, 0, 0, 3 - i / 4, 1, 0, 0);
        step(0, 0, 0, 1, 5, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 5, 1, 0, 0);
        // Tick coinciding with pause is still applied
        step(0, 0, 1, 0, 4, 0, 0, 0);
        step(0, 0, 0, 0, 4, 1, 0, 0);

        // Reset mid-RUN at seconds=2
        step(1, 0, 0, 0, 3, 0, 0, 0);
        step(0, 1, 0, 0, 3, 1, 0, 0);
        for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 3 - i / 4, 1, 0, 0);
        step(1, 0, 0, 0, 3, 0, 0, 0);
        step(0, 0, 0, 0, 3, 0, 0, 0);

        // Reset coinciding with the expiring tick wins
        step(0, 1, 0, 0, 3, 1, 0, 0);
        for (int i = 1; i <= 11; i++) step(0, 0, 0, 0, 3 - i / 4, 1, 0, 0);
        step(1, 0, 0, 0, 3, 0, 0, 0);
        step(0, 0, 0, 0, 3, 0, 0, 0);

        // start+pause together in IDLE -> RUN then PAUSED; start ignored in PAUSED
        step(0, 1, 1, 0, 3, 1, 0, 0);
        step(0, 0, 1, 0, 3, 0, 0, 0);
        step(0, 1, 1, 0, 3, 0, 0, 0);
        step(0, 0, 0, 0, 3, 1, 0, 0);
        step(0, 0, 0, 0, 3, 1, 0, 0);
        step(0, 0, 0, 0, 3, 1, 0, 0);
        step(0, 0, 0, 0, 2, 1, 0, 0);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
